// File: rtl/sn74xx393_modctl_pkg.sv
// Shared sn74lib constants for the SN74XX393 modulo controller:
// counter width default and FSM state encodings.
package sn74xx393_modctl_pkg;

    localparam int SN74_WIDTH = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_CLEAR = 2'd2;

endpackage

// File: rtl/sn74xx_wrapcnt.sv
// Wrap tally: W-bit increment counter with async clear and a sticky
// overflow flag raised when the count rolls from all-ones back to zero.
module sn74xx_wrapcnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         ovf
);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            count <= '0;
            ovf   <= 1'b0;
        end else if (inc) begin
            count <= count + W'(1);
            if (&count)
                ovf <= 1'b1;
        end
    end

endmodule

// File: rtl/sn74xx393_modctl.sv
// Modulo controller for the SN74XX393: checks the count sequence, clears the
// counter at a programmable terminal count and tallies wraps.
module sn74xx393_modctl
    import sn74xx393_modctl_pkg::*;
#(
    parameter int WIDTH      = SN74_WIDTH,
    parameter int CLR_CYCLES = 2,
    parameter int WRAP_W     = 8
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              en,
    input  logic [WIDTH-1:0]  modulo,
    input  logic [WIDTH-1:0]  cnt,
    output logic              cnt_clr,
    output logic              tc,
    output logic [WRAP_W-1:0] wraps,
    output logic              wrap_ovf,
    output logic              seq_err
);

    localparam logic [3:0] HOLD_INIT = 4'(CLR_CYCLES);

    logic [1:0]       state;
    logic [WIDTH-1:0] exp_q;
    logic [WIDTH-1:0] mod_q;
    logic [3:0]       hold;
    logic             step_ok;
    logic             tc_evt;
    logic             last_clr;

    // A hold or a single +1 step (modulo 2^WIDTH) is a legal sample.
    assign step_ok  = (cnt == exp_q) || (cnt == exp_q + WIDTH'(1));
    assign tc_evt   = (state == ST_RUN) && step_ok && (mod_q != '0) && (cnt == mod_q);
    assign last_clr = (state == ST_CLEAR) && (hold == 4'd1);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state   <= ST_IDLE;
            cnt_clr <= 1'b1;
            tc      <= 1'b0;
            seq_err <= 1'b0;
            exp_q   <= '0;
            mod_q   <= '0;
            hold    <= '0;
        end else begin
            tc <= tc_evt;
            case (state)
                ST_IDLE: begin
                    if (en) begin
                        state   <= ST_RUN;
                        mod_q   <= modulo;
                        exp_q   <= '0;
                        cnt_clr <= 1'b0;
                    end
                end
                ST_RUN: begin
                    // Always follow the counter; an illegal jump resyncs here.
                    exp_q <= cnt;
                    if (!step_ok)
                        seq_err <= 1'b1;
                    if (tc_evt) begin
                        state   <= ST_CLEAR;
                        cnt_clr <= 1'b1;
                        hold    <= HOLD_INIT;
                    end
                end
                ST_CLEAR: begin
                    hold <= hold - 4'd1;
                    if (last_clr) begin
                        state   <= ST_RUN;
                        exp_q   <= '0;
                        cnt_clr <= 1'b0;
                        if (cnt != '0)
                            seq_err <= 1'b1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    cnt_clr <= 1'b1;
                end
            endcase
            // Disable wins over any transition above, but tc/wraps still record it.
            if (!en && state != ST_IDLE) begin
                state   <= ST_IDLE;
                cnt_clr <= 1'b1;
            end
        end
    end

    sn74xx_wrapcnt #(.W(WRAP_W)) u_wrapcnt (
        .clk   (clk),
        .clr   (clr),
        .inc   (tc_evt),
        .count (wraps),
        .ovf   (wrap_ovf)
    );

endmodule

// File: tb/tb_sn74xx393_modctl.sv
// Bench for sn74xx393_modctl: behavioural 393 in the loop or a stub count bus,
// checked against a rule-level reference model plus a vector table.
module tb_sn74xx393_modctl;

    localparam int W  = 4;
    localparam int CC = 2;
    localparam int WW = 2;

    logic          clk = 1'b0;
    logic          clr = 1'b0;
    logic          en  = 1'b0;
    logic [W-1:0]  modulo = '0;
    logic [W-1:0]  cnt;
    logic          cnt_clr, tc, wrap_ovf, seq_err;
    logic [WW-1:0] wraps;

    logic [W-1:0]  ctr  = '0;
    logic [W-1:0]  stub = '0;
    logic          use_stub = 1'b0;

    int total = 0;
    int bad   = 0;

    // reference model: on/off, remaining clear edges (0 = counting), running tallies
    bit m_on, m_err, m_tc;
    int m_left, m_exp, m_mod, m_wraps;
    int s_cnt, s_en, s_mod;

    typedef struct {
        logic       en;
        logic [3:0] m;
        logic [3:0] c;
        logic       tc;
        logic       cc;
        logic [1:0] w;
        logic       e;
    } vec_t;
    vec_t tv[8];

    sn74xx393_modctl #(.WIDTH(W), .CLR_CYCLES(CC), .WRAP_W(WW)) dut (
        .clk      (clk),
        .clr      (clr),
        .en       (en),
        .modulo   (modulo),
        .cnt      (cnt),
        .cnt_clr  (cnt_clr),
        .tc       (tc),
        .wraps    (wraps),
        .wrap_ovf (wrap_ovf),
        .seq_err  (seq_err)
    );

    always #5 clk = ~clk;

    // SN74XX393 stand-in: async clear, advances on falling edges
    always @(negedge clk or posedge cnt_clr) begin
        if (cnt_clr) ctr <= '0;
        else         ctr <= ctr + 4'd1;
    end

    assign cnt = use_stub ? stub : ctr;

    function automatic vec_t mk(int e, int m, int c, int t, int k, int w, int er);
        vec_t v;
        v.en = e[0]; v.m = 4'(m); v.c = 4'(c); v.tc = t[0]; v.cc = k[0]; v.w = 2'(w); v.e = er[0];
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, want, $time);
        end
    endtask

    task automatic model_reset();
        m_on = 0; m_err = 0; m_tc = 0; m_left = 0; m_exp = 0; m_mod = 0; m_wraps = 0;
    endtask

    task automatic model_step();
        bit ok;
        m_tc = 0;
        if (!m_on) begin
            if (s_en != 0) begin
                m_on = 1; m_mod = s_mod; m_exp = 0; m_left = 0;
            end
        end else begin
            if (m_left == 0) begin
                ok = (s_cnt == m_exp) || (s_cnt == (m_exp + 1) % 16);
                if (!ok) m_err = 1;
                m_exp = s_cnt;
                if (ok && m_mod != 0 && s_cnt == m_mod) begin
                    m_tc = 1; m_wraps++; m_left = CC;
                end
            end else begin
                if (m_left == 1) begin
                    if (s_cnt != 0) m_err = 1;
                    m_exp = 0;
                end
                m_left--;
            end
            if (s_en == 0) begin
                m_on = 0; m_left = 0;
            end
        end
    endtask

    task automatic check_model();
        check("tc", tc, m_tc);
        check("cnt_clr", cnt_clr, (!m_on || m_left > 0));
        check("wraps", wraps, m_wraps % (1 << WW));
        check("wrap_ovf", wrap_ovf, m_wraps >= (1 << WW));
        check("seq_err", seq_err, m_err);
    endtask

    // one rising edge: sample inputs just before it, model it, compare just after
    task automatic tick(input int drop_at);
        @(negedge clk);
        #1;
        if (drop_at >= 0 && int'(cnt) == drop_at) en = 1'b0;
        s_cnt = int'(cnt); s_en = int'(en); s_mod = int'(modulo);
        @(posedge clk);
        #1;
        model_step();
        check_model();
    endtask

    // async reset pulse between edges; outputs must settle without a clock
    task automatic do_reset();
        #1;
        clr = 1'b1;
        #1;
        check("rst cnt_clr", cnt_clr, 1);
        check("rst tc", tc, 0);
        check("rst wraps", wraps, 0);
        check("rst wrap_ovf", wrap_ovf, 0);
        check("rst seq_err", seq_err, 0);
        model_reset();
        clr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses[4];
        int np, tcs, r;
        bit saw15, wrapped;

        tv[0] = mk(1, 4, 0, 0, 0, 0, 0);
        tv[1] = mk(1, 9, 1, 0, 0, 0, 0);
        tv[2] = mk(1, 9, 3, 0, 0, 0, 1);
        tv[3] = mk(1, 9, 4, 1, 1, 1, 1);
        tv[4] = mk(1, 9, 0, 0, 1, 1, 1);
        tv[5] = mk(1, 9, 0, 0, 0, 1, 1);
        tv[6] = mk(1, 9, 1, 0, 0, 1, 1);
        tv[7] = mk(0, 9, 2, 0, 1, 1, 1);

        // vector table: step error at 3, resync, terminal count at latched 4
        do_reset();
        use_stub = 1'b1;
        for (int i = 0; i < 8; i++) begin
            en = tv[i].en; modulo = tv[i].m; stub = tv[i].c;
            tick(-1);
            check($sformatf("vec%0d tc", i), tc, tv[i].tc);
            check($sformatf("vec%0d cnt_clr", i), cnt_clr, tv[i].cc);
            check($sformatf("vec%0d wraps", i), wraps, tv[i].w);
            check($sformatf("vec%0d seq_err", i), seq_err, tv[i].e);
        end

        // divide by 5 with the counter in the loop
        do_reset();
        use_stub = 1'b0; modulo = 4'd5; en = 1'b1; np = 0;
        for (int i = 0; i < 60 && np < 3; i++) begin
            tick(-1);
            if (tc) begin pulses[np] = i; np++; end
        end
        check("div pulses", np, 3);
        check("div period a", pulses[1] - pulses[0], 5 + CC);
        check("div period b", pulses[2] - pulses[1], 5 + CC);
        check("div wraps", wraps, 3);
        check("div seq_err", seq_err, 0);
        tick(-1);
        tick(-1);
        do_reset();

        // free run: modulo 0 never terminates, 15->0 is legal
        modulo = 4'd0; en = 1'b1; tcs = 0; saw15 = 0; wrapped = 0;
        for (int i = 0; i < 40; i++) begin
            tick(-1);
            if (tc) tcs++;
            if (saw15 && s_cnt == 0) wrapped = 1;
            saw15 = (s_cnt == 15);
        end
        check("free tc count", tcs, 0);
        check("free wrapped", wrapped, 1);
        check("free wraps", wraps, 0);
        check("free seq_err", seq_err, 0);

        // tally overflow with a 2-bit wrap counter
        do_reset();
        modulo = 4'd1; en = 1'b1; tcs = 0;
        for (int i = 0; i < 60 && tcs < 4; i++) begin
            tick(-1);
            if (tc) tcs++;
        end
        check("ovf tc count", tcs, 4);
        check("ovf wraps", wraps, 0);
        check("ovf flag", wrap_ovf, 1);

        // enable drops on the terminal-count edge
        do_reset();
        modulo = 4'd3; en = 1'b1;
        for (int i = 0; i < 20 && en; i++) tick(3);
        check("race tc", tc, 1);
        check("race wraps", wraps, 1);
        check("race cnt_clr", cnt_clr, 1);
        tick(-1);
        check("race tc gone", tc, 0);
        check("race idle", cnt_clr, 1);

        // randomized stub traffic against the model
        do_reset();
        use_stub = 1'b1; en = 1'b1; modulo = 4'($urandom_range(0, 15));
        for (int i = 0; i < 400; i++) begin
            if (i % 97 == 96) do_reset();
            en = ($urandom_range(0, 99) < 4) ? 1'b0 : 1'b1;
            if ($urandom_range(0, 9) == 0) modulo = 4'($urandom_range(0, 15));
            r = int'($urandom_range(0, 99));
            if (cnt_clr)      stub = (r < 85) ? 4'd0 : 4'($urandom_range(0, 15));
            else if (r < 65)  stub = 4'(s_cnt + 1);
            else if (r < 85)  stub = 4'(s_cnt);
            else              stub = 4'($urandom_range(0, 15));
            tick(-1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
